// File: rtl/router_fifo.sv
// Packet-aware 16x9 output buffer for one router port.
// Tracks remaining payload+parity bytes after a header is read out.
module router_fifo #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 9,
    parameter int ADD_SIZE = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic             soft_reset,
    input  logic [WIDTH-2:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-2:0] data_out
);

    localparam int DW  = WIDTH - 1;
    localparam int IDX = ADD_SIZE - 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [ADD_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADD_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]          count_q, count_d;
    logic [DW-1:0]       data_q, data_d;
    logic                do_wr, do_rd;
    logic [WIDTH-1:0]    rd_word;

    // The wrap bit separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q == {~rd_ptr_q[IDX], rd_ptr_q[IDX-1:0]});

    assign do_wr   = write_enb && !full && !soft_reset;
    assign do_rd   = read_enb && !empty && !soft_reset;
    assign rd_word = mem_q[rd_ptr_q[IDX-1:0]];

    assign data_out = data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            data_d   = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                data_d   = rd_word[DW-1:0];
                // Header length field plus the trailing parity byte.
                if (rd_word[WIDTH-1]) begin
                    count_d = {1'b0, rd_word[DW-1:2]} + 7'd1;
                end else if (count_q != '0) begin
                    count_d = count_q - 7'd1;
                end
            end else if (count_q == '0) begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_wr) begin
            mem_q[wr_ptr_q[IDX-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed and random checks of router_fifo against a queue-based model.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic       soft_reset;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int nasrt = 0;
    int nfail = 0;

    logic [8:0] q[$];
    int         m_cnt;
    logic [7:0] m_dout;
    logic [7:0] pl[10];

    router_fifo #(.DEPTH(16), .WIDTH(9), .ADD_SIZE(5)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .soft_reset (soft_reset),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".full"}, {8'h0, full}, {8'h0, q.size() == 16});
        chk({tag, ".empty"}, {8'h0, empty}, {8'h0, q.size() == 0});
        chk({tag, ".dout"}, {1'b0, data_out}, {1'b0, m_dout});
    endtask

    task automatic model_clear();
        q.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
    endtask

    // Behaviour of one clock edge given the current inputs.
    task automatic model_edge();
        bit rd, wr;
        logic [8:0] w;
        if (soft_reset) begin
            model_clear();
            return;
        end
        rd = read_enb && q.size() > 0;
        wr = write_enb && q.size() < 16;
        if (rd) begin
            w = q.pop_front();
            m_dout = w[7:0];
            if (w[8]) m_cnt = int'(w[7:2]) + 1;
            else if (m_cnt > 0) m_cnt--;
        end else if (m_cnt == 0) begin
            m_dout = 8'h00;
        end
        if (wr) q.push_back({lfd_state, data_in});
    endtask

    task automatic drive(input logic w, input logic r, input logic l,
                         input logic s, input logic [7:0] d);
        write_enb  = w;
        read_enb   = r;
        lfd_state  = l;
        soft_reset = s;
        data_in    = d;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    initial begin
        logic [7:0] par;
        drive(0, 0, 0, 0, 8'h00);
        resetn = 1'b1;
        model_clear();
        @(posedge clock);
        #1;
        compare("reset_hold");
        resetn = 1'b0;
        #1;
        compare("reset_rel");

        // One packet: header 0x22 carries payload length 8
        par = 8'h22;
        drive(1, 0, 1, 0, 8'h22);
        step("hdr_wr");
        for (int i = 0; i < 8; i++) begin
            pl[i] = 8'($urandom);
            par ^= pl[i];
            drive(1, 0, 0, 0, pl[i]);
            step("pay_wr");
        end
        drive(1, 0, 0, 0, par);
        step("par_wr");
        drive(0, 0, 0, 0, 8'h00);
        chk("pkt_size", 9'(q.size()), 9'd10);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            step("pkt_rd");
            if (i == 0) chk("hdr_out", {1'b0, data_out}, 9'h022);
            else if (i == 9) chk("par_out", {1'b0, data_out}, {1'b0, par});
            else chk("pay_out", {1'b0, data_out}, {1'b0, pl[i-1]});
        end
        drive(0, 0, 0, 0, 8'h00);
        step("idle0");
        chk("idle_zero", {1'b0, data_out}, 9'h000);
        step("idle1");

        // Overflow: 17th write dropped
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 0, 8'(i + 8'h40));
            step("ovf_wr");
        end
        chk("ovf_full", {8'h0, full}, 9'h001);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            step("ovf_rd");
            chk("ovf_order", {1'b0, data_out}, 9'(i + 8'h40));
        end

        // Refill, then read+write while full
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 8'($urandom));
            step("fill_wr");
        end
        drive(1, 1, 0, 0, 8'hEE);
        step("full_rw");
        chk("full_rw_nf", {8'h0, full}, 9'h000);
        for (int i = 0; i < 15; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            step("full_drain");
        end

        // Half-full streaming across the index wrap
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 8'($urandom));
            step("half_wr");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 8'($urandom));
            step("wrap_rw");
        end
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 0, 8'h00);
            step("wrap_drain");
        end

        // Soft reset overriding concurrent access
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, i == 0, 0, 8'($urandom_range(8'h3F, 8'h04)));
            step("sr_fill");
        end
        drive(0, 1, 0, 0, 8'h00);
        step("sr_rd1");
        drive(1, 1, 0, 1, 8'h77);
        step("sr_pulse");
        chk("sr_empty", {8'h0, empty}, 9'h001);
        drive(0, 1, 0, 0, 8'h00);
        step("sr_rd_after");
        chk("sr_dout", {1'b0, data_out}, 9'h000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 55),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 15),
                  1'($urandom_range(0, 99) < 2),
                  8'($urandom));
            step("rand");
        end

        // Asynchronous reset mid-packet
        drive(1, 0, 1, 0, 8'h30);
        step("ar_hdr");
        drive(1, 1, 0, 0, 8'h5A);
        step("ar_pay");
        drive(0, 0, 0, 0, 8'h00);
        #2;
        resetn = 1'b1;
        #1;
        model_clear();
        compare("async_rst");
        @(posedge clock);
        #1;
        resetn = 1'b0;
        compare("async_rel");
        drive(0, 1, 0, 0, 8'h00);
        step("ar_rd");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end

endmodule
